// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM->WB pipeline stage: control-bit positions and
// the default-width payload record.
package mem_wb_pkg;

    localparam int unsigned CTRL_REGWRITE = 0;
    localparam int unsigned CTRL_MEMTOREG = 1;

    localparam int unsigned MW_LANES_DEF  = 4;
    localparam int unsigned MW_LANE_W_DEF = 8;
    localparam int unsigned MW_ALU_W_DEF  = 32;
    localparam int unsigned MW_DEST_W_DEF = 5;
    localparam int unsigned MW_CTRL_W_DEF = 2;

    typedef struct packed {
        logic [MW_LANES_DEF*MW_LANE_W_DEF-1:0] lanes;
        logic [MW_DEST_W_DEF-1:0]              dest;
        logic [MW_CTRL_W_DEF-1:0]              ctrl;
        logic [MW_ALU_W_DEF-1:0]               alu;
    } mem_wb_payload_t;

endpackage

// File: rtl/mem_wb_pipe_stage_if.sv
// Upstream/downstream handshake, payload and forwarding bundle of the MEM->WB stage.
// slave = the stage itself, master = the surrounding pipeline.
interface mem_wb_pipe_stage_if #(
    parameter int unsigned DATA_LANES = 4,
    parameter int unsigned LANE_W     = 8,
    parameter int unsigned ALU_W      = 32,
    parameter int unsigned DEST_W     = 5,
    parameter int unsigned CTRL_W     = 2
);
    logic                         in_valid;
    logic                         in_ready;
    logic [DATA_LANES*LANE_W-1:0] in_lanes;
    logic [DEST_W-1:0]            in_dest;
    logic [CTRL_W-1:0]            in_ctrl;
    logic [ALU_W-1:0]             in_alu;

    logic                         out_valid;
    logic                         out_ready;
    logic [DATA_LANES*LANE_W-1:0] out_lanes;
    logic [DEST_W-1:0]            out_dest;
    logic [CTRL_W-1:0]            out_ctrl;
    logic [ALU_W-1:0]             out_alu;

    logic                         fwd_valid;
    logic [DEST_W-1:0]            fwd_dest;
    logic [ALU_W-1:0]             fwd_data;

    modport slave (
        input  in_valid, in_lanes, in_dest, in_ctrl, in_alu, out_ready,
        output in_ready, out_valid, out_lanes, out_dest, out_ctrl, out_alu,
        output fwd_valid, fwd_dest, fwd_data
    );

    modport master (
        output in_valid, in_lanes, in_dest, in_ctrl, in_alu, out_ready,
        input  in_ready, out_valid, out_lanes, out_dest, out_ctrl, out_alu,
        input  fwd_valid, fwd_dest, fwd_data
    );
endinterface

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry head/skid buffer with a registered ready. acc_i/pop_i arrive
// already qualified by the parent; flush_i wins over both.
module pipe_skid_buf #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush_i,
    input  logic acc_i,
    input  logic pop_i,
    input  T     din_i,
    output T     head_o,
    output logic head_valid_o,
    output logic in_ready_o
);
    T     head_q, head_d;
    T     skid_q, skid_d;
    logic head_valid_q, head_valid_d;
    logic skid_valid_q, skid_valid_d;
    logic ready_q, ready_d;

    // acc_i implies ready_q, i.e. skid empty, so the skid slot is always free on accept.
    always_comb begin
        head_d       = head_q;
        skid_d       = skid_q;
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush_i) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (pop_i) begin
            if (skid_valid_q) begin
                head_d       = skid_q;
                head_valid_d = 1'b1;
                skid_valid_d = acc_i;
                if (acc_i) skid_d = din_i;
            end else begin
                head_valid_d = acc_i;
                if (acc_i) head_d = din_i;
            end
        end else if (acc_i) begin
            if (!head_valid_q) begin
                head_d       = din_i;
                head_valid_d = 1'b1;
            end else begin
                skid_d       = din_i;
                skid_valid_d = 1'b1;
            end
        end
        ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q       <= '0;
            skid_q       <= '0;
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            head_q       <= head_d;
            skid_q       <= skid_d;
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
        end
    end

    assign head_o       = head_q;
    assign head_valid_o = head_valid_q;
    assign in_ready_o   = ready_q;
endmodule

// File: rtl/mem_wb_pipe_stage.sv
// MEM->WB pipeline stage: hold/flush gating around pipe_skid_buf plus write-back forwarding.
// Define MEM_WB_PIPE_PERF_EN to add saturating stall_cnt/bubble_cnt outputs.
module mem_wb_pipe_stage
    import mem_wb_pkg::*;
#(
    parameter int unsigned DATA_LANES = 4,
    parameter int unsigned LANE_W     = 8,
    parameter int unsigned ALU_W      = 32,
    parameter int unsigned DEST_W     = 5,
    parameter int unsigned CTRL_W     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                hold,
    input  logic                flush,
    mem_wb_pipe_stage_if.slave  bus
`ifdef MEM_WB_PIPE_PERF_EN
    ,
    output logic [31:0]         stall_cnt,
    output logic [31:0]         bubble_cnt
`endif
);
    if (ALU_W != DATA_LANES*LANE_W) begin : g_width_check
        $error("mem_wb_pipe_stage: ALU_W must equal DATA_LANES*LANE_W");
    end

    typedef struct packed {
        logic [DATA_LANES*LANE_W-1:0] lanes;
        logic [DEST_W-1:0]            dest;
        logic [CTRL_W-1:0]            ctrl;
        logic [ALU_W-1:0]             alu;
    } payload_t;

    payload_t din, head;
    logic     head_valid;
    logic     in_ready;
    logic     acc;
    logic     pop;

    assign acc = bus.in_valid & in_ready & ~hold & ~flush;
    assign pop = head_valid & bus.out_ready & ~hold;

    assign din.lanes = bus.in_lanes;
    assign din.dest  = bus.in_dest;
    assign din.ctrl  = bus.in_ctrl;
    assign din.alu   = bus.in_alu;

    pipe_skid_buf #(
        .T (payload_t)
    ) u_skid (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush),
        .acc_i        (acc),
        .pop_i        (pop),
        .din_i        (din),
        .head_o       (head),
        .head_valid_o (head_valid),
        .in_ready_o   (in_ready)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = head_valid;
    assign bus.out_lanes = head.lanes;
    assign bus.out_dest  = head.dest;
    assign bus.out_ctrl  = head.ctrl;
    assign bus.out_alu   = head.alu;

    // Forwarding reads only the head registers, so no in_* -> fwd_* path exists.
    assign bus.fwd_valid = head_valid & head.ctrl[CTRL_REGWRITE] & (head.dest != '0);
    assign bus.fwd_dest  = head.dest;
    assign bus.fwd_data  = head.ctrl[CTRL_MEMTOREG] ? head.lanes : head.alu;

`ifdef MEM_WB_PIPE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (head_valid && !pop && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
        if (!head_valid && bubble_cnt_q != '1)      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Directed self-checking bench for mem_wb_pipe_stage (default widths).
// Counter checks are compiled in when MEM_WB_PIPE_PERF_EN is defined.
module tb_mem_wb_pipe_stage;
    import mem_wb_pkg::*;

    logic clk;
    logic rst_n;
    logic hold;
    logic flush;
    int   n_tests;
    int   n_fail;

    mem_wb_pipe_stage_if #(
        .DATA_LANES (4),
        .LANE_W     (8),
        .ALU_W      (32),
        .DEST_W     (5),
        .CTRL_W     (2)
    ) bus ();

`ifdef MEM_WB_PIPE_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;
    logic [31:0] stall_base;
    logic [31:0] bubble_base;
`endif

    mem_wb_pipe_stage #(
        .DATA_LANES (4),
        .LANE_W     (8),
        .ALU_W      (32),
        .DEST_W     (5),
        .CTRL_W     (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (hold),
        .flush (flush),
        .bus   (bus)
`ifdef MEM_WB_PIPE_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic mem_wb_payload_t mk(input int k);
        mem_wb_payload_t p;
        p.lanes = 32'hA000_0000 | 32'(k);
        p.dest  = 5'((k % 31) + 1);
        p.ctrl  = 2'b01;
        p.alu   = 32'h0000_0100 + 32'(k);
        return p;
    endfunction

    task automatic drive(input logic v, input mem_wb_payload_t p);
        bus.in_valid = v;
        bus.in_lanes = p.lanes;
        bus.in_dest  = p.dest;
        bus.in_ctrl  = p.ctrl;
        bus.in_alu   = p.alu;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input int k);
        mem_wb_payload_t e;
        e = mk(k);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_alu"},   64'(bus.out_alu),   64'(e.alu));
        check({tag, "_lanes"}, 64'(bus.out_lanes), 64'(e.lanes));
        check({tag, "_dest"},  64'(bus.out_dest),  64'(e.dest));
    endtask

    mem_wb_payload_t fp;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        hold  = 1'b0;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, '0);

        // Reset state
        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_alu",   64'(bus.out_alu),   64'd0);
        check("rst_fwd_valid", 64'(bus.fwd_valid), 64'd0);
`ifdef MEM_WB_PIPE_PERF_EN
        check("rst_stall_cnt",  64'(stall_cnt),  64'd0);
        check("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
`endif
        rst_n = 1'b1;
        step();

        // Streaming: one entry per cycle, one-cycle latency
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, mk(i));
            step();
            check_head($sformatf("s2_e%0d", i), i);
            check("s2_in_ready", 64'(bus.in_ready), 64'd1);
        end
        drive(1'b0, '0);
        step();
        check("s2_drain", 64'(bus.out_valid), 64'd0);

        // Backpressure fills head then skid; ready drops, order kept
        bus.out_ready = 1'b0;
        drive(1'b1, mk(10));
        step();
        check_head("s3_c1", 10);
        check("s3_c1_ready", 64'(bus.in_ready), 64'd1);
`ifdef MEM_WB_PIPE_PERF_EN
        stall_base  = stall_cnt;
        bubble_base = bubble_cnt;
`endif
        drive(1'b1, mk(11));
        step();
        check_head("s3_c2", 10);
        check("s3_c2_ready", 64'(bus.in_ready), 64'd0);
        drive(1'b1, mk(12));
        step();
        check_head("s3_c3", 10);
        check("s3_c3_ready", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        step();
        check_head("s3_pop1", 11);
        check("s3_pop1_ready", 64'(bus.in_ready), 64'd1);
`ifdef MEM_WB_PIPE_PERF_EN
        check("s3_stall_delta",  64'(stall_cnt - stall_base),   64'd2);
        check("s3_bubble_delta", 64'(bubble_cnt - bubble_base), 64'd0);
`endif
        step();
        check_head("s3_pop2", 12);
        drive(1'b0, '0);
        step();
        check("s3_drain", 64'(bus.out_valid), 64'd0);

        // Hold freezes the head and blocks acceptance
        drive(1'b1, mk(30));
        step();
        check_head("s4_pre", 30);
        hold = 1'b1;
        drive(1'b1, mk(31));
        for (int i = 0; i < 4; i++) begin
            step();
            check_head($sformatf("s4_hold%0d", i), 30);
            check("s4_hold_ready", 64'(bus.in_ready), 64'd1);
        end
        hold = 1'b0;
        step();
        check_head("s4_resume", 31);
        drive(1'b0, '0);
        step();
        check("s4_drain", 64'(bus.out_valid), 64'd0);

        // Flush with two entries buffered and a same-cycle input
        bus.out_ready = 1'b0;
        drive(1'b1, mk(20));
        step();
        drive(1'b1, mk(21));
        step();
        check("s5_full_ready", 64'(bus.in_ready), 64'd0);
        flush = 1'b1;
        drive(1'b1, mk(22));
        step();
        check("s5_flush_valid", 64'(bus.out_valid), 64'd0);
        check("s5_flush_ready", 64'(bus.in_ready),  64'd1);
        check("s5_flush_fwd",   64'(bus.fwd_valid), 64'd0);
`ifdef MEM_WB_PIPE_PERF_EN
        stall_base  = stall_cnt;
        bubble_base = bubble_cnt;
`endif
        flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, '0);
        step();
        check("s5_after_valid", 64'(bus.out_valid), 64'd0);
`ifdef MEM_WB_PIPE_PERF_EN
        check("s5_bubble_delta", 64'(bubble_cnt - bubble_base), 64'd1);
        check("s5_stall_delta",  64'(stall_cnt - stall_base),   64'd0);
`endif
        drive(1'b1, mk(23));
        step();
        check_head("s5_next", 23);
        drive(1'b0, '0);
        step();
        check("s5_drain", 64'(bus.out_valid), 64'd0);

        // Forwarding
        bus.out_ready = 1'b0;
        fp.lanes = 32'hAABB_CCDD;
        fp.dest  = 5'd5;
        fp.ctrl  = 2'b11;
        fp.alu   = 32'h0000_0001;
        drive(1'b1, fp);
        step();
        check("s6_mem_fwd_valid", 64'(bus.fwd_valid), 64'd1);
        check("s6_mem_fwd_data",  64'(bus.fwd_data),  64'hAABB_CCDD);
        check("s6_mem_fwd_dest",  64'(bus.fwd_dest),  64'd5);
        bus.out_ready = 1'b1;
        fp.ctrl = 2'b01;
        drive(1'b1, fp);
        step();
        check("s6_alu_fwd_valid", 64'(bus.fwd_valid), 64'd1);
        check("s6_alu_fwd_data",  64'(bus.fwd_data),  64'h1);
        fp.dest = 5'd0;
        drive(1'b1, fp);
        step();
        check("s6_r0_fwd_valid", 64'(bus.fwd_valid), 64'd0);
        fp.dest = 5'd7;
        fp.ctrl = 2'b10;
        drive(1'b1, fp);
        step();
        check("s6_nowr_fwd_valid", 64'(bus.fwd_valid), 64'd0);
        check("s6_nowr_fwd_data",  64'(bus.fwd_data),  64'hAABB_CCDD);
        drive(1'b0, '0);
        step();
        check("s6_drain", 64'(bus.out_valid), 64'd0);

        // Asynchronous reset mid-traffic
        bus.out_ready = 1'b0;
        drive(1'b1, mk(40));
        step();
        drive(1'b1, mk(41));
        step();
        check("s1_pre_ready", 64'(bus.in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("s1_async_valid", 64'(bus.out_valid), 64'd0);
        check("s1_async_ready", 64'(bus.in_ready),  64'd1);
        check("s1_async_alu",   64'(bus.out_alu),   64'd0);
        check("s1_async_lanes", 64'(bus.out_lanes), 64'd0);
        check("s1_async_fwd",   64'(bus.fwd_valid), 64'd0);
        drive(1'b0, '0);
        #3;
        rst_n = 1'b1;
        step();
        check("s1_post_valid", 64'(bus.out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
